// File: rtl/falafel_mem_cas_adapter_pkg.sv
// Shared types and constants for the falafel LSU memory/CAS adapter.
package falafel_mem_cas_adapter_pkg;

  localparam int unsigned DATA_W = 64;

  // Key value the LSU treats as "unlocked"; a CAS returning it with cas_exp 0 acquired the lock
  localparam logic [DATA_W-1:0] EMPTY_KEY = '0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    ISSUE_WR,
    WAIT_WR,
    RSP
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_STORE,
    OP_CAS
  } op_e;

endpackage

// File: rtl/falafel_mem_cas_adapter.sv
// Terminates the LSU request/response port on a single-port memory backend,
// running loads/stores as one backend access and CAS as an atomic read-compare-write.
module falafel_mem_cas_adapter
  import falafel_mem_cas_adapter_pkg::*;
#(
  parameter int unsigned DATA_W = falafel_mem_cas_adapter_pkg::DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o,
  output logic              be_req_o,
  input  logic              be_gnt_i,
  output logic              be_we_o,
  output logic [DATA_W-1:0] be_addr_o,
  output logic [DATA_W-1:0] be_wdata_o,
  input  logic              be_rvalid_i,
  input  logic [DATA_W-1:0] be_rdata_i,
  output logic [CNT_W-1:0]  cas_ok_cnt_o,
  output logic [CNT_W-1:0]  cas_fail_cnt_o
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d, req_op;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    ok_q, ok_d;
  logic [CNT_W-1:0]    fail_q, fail_d;

  logic                req_rdy_q, req_rdy_d;
  logic                be_req_q, be_req_d;
  logic                be_we_q, be_we_d;
  logic [DATA_W-1:0]   be_addr_q, be_addr_d;
  logic [DATA_W-1:0]   be_wdata_q, be_wdata_d;
  logic                rsp_val_q, rsp_val_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  // Next-state, request capture and CAS statistics
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    exp_d   = exp_q;
    rdata_d = rdata_q;
    ok_d    = ok_q;
    fail_d  = fail_q;
    req_op  = mem_req_is_cas_i   ? OP_CAS   :
              mem_req_is_write_i ? OP_STORE : OP_LOAD;

    unique case (state_q)
      IDLE: begin
        if (mem_req_val_i && req_rdy_q) begin
          op_d    = req_op;
          addr_d  = mem_req_addr_i;
          data_d  = mem_req_data_i;
          exp_d   = mem_req_cas_exp_i;
          state_d = (req_op == OP_STORE) ? ISSUE_WR : ISSUE_RD;
        end
      end
      ISSUE_RD: if (be_gnt_i) state_d = WAIT_RD;
      WAIT_RD: begin
        if (be_rvalid_i) begin
          rdata_d = be_rdata_i;
          if (op_q != OP_CAS) begin
            state_d = RSP;
          end else if (be_rdata_i == exp_q) begin
            state_d = ISSUE_WR;
            ok_d    = (ok_q == '1) ? ok_q : ok_q + CNT_W'(1);
          end else begin
            state_d = RSP;
            fail_d  = (fail_q == '1) ? fail_q : fail_q + CNT_W'(1);
          end
        end
      end
      ISSUE_WR: if (be_gnt_i) state_d = WAIT_WR;
      WAIT_WR:  if (be_rvalid_i) state_d = RSP;
      RSP:      if (mem_rsp_rdy_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they belong to
  always_comb begin
    req_rdy_d  = (state_d == IDLE);
    be_req_d   = (state_d == ISSUE_RD) || (state_d == ISSUE_WR);
    be_we_d    = (state_d == ISSUE_WR);
    be_addr_d  = be_req_d ? addr_d : '0;
    be_wdata_d = be_we_d ? data_d : '0;
    rsp_val_d  = (state_d == RSP);
    rsp_data_d = (rsp_val_d && (op_d != OP_STORE)) ? rdata_d : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      addr_q     <= '0;
      data_q     <= '0;
      exp_q      <= '0;
      rdata_q    <= '0;
      ok_q       <= '0;
      fail_q     <= '0;
      req_rdy_q  <= 1'b0;
      be_req_q   <= 1'b0;
      be_we_q    <= 1'b0;
      be_addr_q  <= '0;
      be_wdata_q <= '0;
      rsp_val_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      exp_q      <= exp_d;
      rdata_q    <= rdata_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      req_rdy_q  <= req_rdy_d;
      be_req_q   <= be_req_d;
      be_we_q    <= be_we_d;
      be_addr_q  <= be_addr_d;
      be_wdata_q <= be_wdata_d;
      rsp_val_q  <= rsp_val_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign mem_req_rdy_o  = req_rdy_q;
  assign be_req_o       = be_req_q;
  assign be_we_o        = be_we_q;
  assign be_addr_o      = be_addr_q;
  assign be_wdata_o     = be_wdata_q;
  assign mem_rsp_val_o  = rsp_val_q;
  assign mem_rsp_data_o = rsp_data_q;
  assign cas_ok_cnt_o   = ok_q;
  assign cas_fail_cnt_o = fail_q;

endmodule

// File: doc/falafel_mem_cas_adapter.md
Name: falafel_mem_cas_adapter

Overview:
- Sits directly downstream of the falafel LSU and terminates its memory request/response port on a plain single-port read/write memory backend.
- Executes loads and stores as single backend transactions.
- Executes compare-and-swap (CAS) as an atomic read–compare–conditional-write sequence. The adapter serialises all traffic, so no other access can interleave.
- Returns the old memory value for CAS. 0 returned with cas_exp 0 means the lock was acquired.

Parameters:
- DATA_W, 64, width of data, address and CAS expected value (matches package DATA_W).
- CNT_W, 16, width of the saturating CAS statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- mem_req_val_i  in  1  LSU request valid.
- mem_req_rdy_o  out  1  adapter can accept a request.
- mem_req_is_write_i  in  1  1 = store, 0 = load (ignored when is_cas is 1).
- mem_req_is_cas_i  in  1  1 = CAS; takes priority over is_write.
- mem_req_addr_i  in  DATA_W  address.
- mem_req_data_i  in  DATA_W  store data / CAS new value.
- mem_req_cas_exp_i  in  DATA_W  CAS expected value.
- mem_rsp_val_o  out  1  response valid.
- mem_rsp_rdy_i  in  1  LSU ready for response.
- mem_rsp_data_o  out  DATA_W  load data / CAS old value / 0 for stores.
- be_req_o  out  1  backend request.
- be_gnt_i  in  1  backend accepted request this cycle.
- be_we_o  out  1  backend write enable.
- be_addr_o  out  DATA_W  backend address.
- be_wdata_o  out  DATA_W  backend write data.
- be_rvalid_i  in  1  backend completion, one pulse per granted request (reads and writes).
- be_rdata_i  in  DATA_W  backend read data, valid with be_rvalid_i.
- cas_ok_cnt_o  out  CNT_W  successful CAS count, saturating.
- cas_fail_cnt_o  out  CNT_W  failed CAS count, saturating.

Behaviour:
- Reset (async, rst_ni low):
  - State goes to IDLE.
  - All outputs 0, except mem_req_rdy_o = 1 once in IDLE after reset deassertion.
  - Request registers and counters are cleared.
  - Reset mid-operation abandons the transaction. The backend shares the same reset, so no stale be_rvalid_i is expected. Any be_rvalid_i seen in IDLE is ignored.
- State machine (registered state):
  - IDLE: mem_req_rdy_o = 1. On mem_req_val_i, capture op, addr, data and cas_exp. Go to ISSUE_RD for a load or CAS, or ISSUE_WR for a store.
  - ISSUE_RD: be_req_o = 1, be_we_o = 0, be_addr_o = addr. Hold until be_gnt_i, then go to WAIT_RD.
  - WAIT_RD: on be_rvalid_i, capture be_rdata_i into rdata_q.
    - Load: go to RSP.
    - CAS with be_rdata_i == cas_exp: go to ISSUE_WR and increment cas_ok.
    - CAS with a mismatch: go to RSP and increment cas_fail.
  - ISSUE_WR: be_req_o = 1, be_we_o = 1, be_addr_o = addr, be_wdata_o = data. Hold until be_gnt_i, then go to WAIT_WR.
  - WAIT_WR: on be_rvalid_i go to RSP. Write-ack be_rdata_i is ignored.
  - RSP: mem_rsp_val_o = 1. mem_rsp_data_o = rdata_q for load/CAS, 0 for store. Hold until mem_rsp_rdy_i, then go to IDLE.
- Handshake rules:
  - mem_req_rdy_o is 1 only in IDLE: one outstanding request.
  - be_req_o and its payload stay stable until be_gnt_i.
  - mem_rsp_val_o and its data stay stable until mem_rsp_rdy_i.
  - be_gnt_i and be_rvalid_i in the same cycle: only be_gnt_i is acted on. be_rvalid_i is guaranteed no earlier than the cycle after grant.
- Latency:
  - Minimum latency from accept to mem_rsp_val_o is 3 cycles for load/store (backend grant same cycle, rvalid next cycle).
  - Minimum for a successful CAS is 5 cycles.
- Atomicity: from CAS capture to RSP no backend request other than that CAS's own read and write is issued.
- Counters: saturate at all-ones and do not wrap. A CAS increments its counter exactly once.
- Outputs are driven from registered state plus held registers only; no combinational path from mem_req_* to be_*.

Decomposition:
- Package: adapter state enum (IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, RSP) and DATA_W.
- Shared with the LSU: EMPTY_KEY value (0) used in tests.
- Single module; no sub-module needed (saturating counter inline).

Test Plan:
- Load: backend memory[0x100] = 0x2A, LSU load addr 0x100 -> one backend read, mem_rsp_data_o = 0x2A, rsp 3 cycles after accept with zero-wait backend.
- Store: addr 0x108, data 0x55 -> one backend write with be_wdata_o = 0x55, response data 0, memory[0x108] = 0x55.
- CAS success: memory[0x200] = 0, CAS exp 0 new 7 -> read then write, rsp data 0, memory = 7, cas_ok_cnt_o = 1.
- CAS fail: memory[0x200] = 7, CAS exp 0 new 9 -> read only, no write, rsp data 7, memory stays 7, cas_fail_cnt_o = 1.
- Backpressure: be_gnt_i delayed 4 cycles and mem_rsp_rdy_i delayed 3 cycles -> be_* and rsp payload stable throughout, mem_req_rdy_o = 0 until response consumed.
- Reset mid-CAS: assert rst_ni low in WAIT_RD -> outputs 0 immediately (async), after release IDLE with rdy = 1, no write issued, counters 0.
